i2s_master_scheduler: RTL and testbench

- Single-clock I2S master controller for a converter slot; clk is the converter master clock (MCLK).
- Derives BCK/LRCK from clk at a run-time MCLK/Fs ratio.
- Schedules one stereo sample fetch per frame from the sample FIFO, using the FIFOInterface ready/enable/data convention, and serialises the sample onto sdata.
- Handles start/stop sequencing and FIFO underrun; sits between the slot's sample FIFO and the isolator pins.

---
 rtl/i2s_pkg.sv | 35 +++
 rtl/i2s_clock_divider.sv | 57 +++++
 rtl/i2s_master_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_i2s_master_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Brief    : Shared state encoding, frame constants and ratio decode for the
//            I2S master scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        RUN      = 2'd2,
        STOPPING = 2'd3
    } fsm_state_t;

    localparam int RATIO_128   = 128;
    localparam int RATIO_256   = 256;
    localparam int RATIO_512   = 512;
    localparam int FRAME_BITS  = 64;
    localparam int c_half_bits = 3;

    // Reserved code 3 falls back to 256Fs.
    function automatic logic [c_half_bits-1:0] ratio_to_half(input logic [1:0] ratio_sel);
        logic [c_half_bits-1:0] half;
        case (ratio_sel)
            2'd0:    half = c_half_bits'(RATIO_128 / 128);
            2'd2:    half = c_half_bits'(RATIO_512 / 128);
            default: half = c_half_bits'(RATIO_256 / 128);
        endcase
        return half;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : i2s_clock_divider
// Brief    : BCK/LRCK generation from MCLK with bit/frame position tracking.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_clock_divider
    import i2s_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enable,
    input  logic [c_half_bits-1:0] i_half,
    output logic                   o_bck,
    output logic                   o_lrck,
    output logic                   o_fall,
    output logic                   o_frame_wrap,
    output logic [5:0]             o_next_bit
);

    logic [c_half_bits:0] r_div_cnt;
    logic [5:0]           r_bit_cnt;
    logic                 r_bck;
    logic                 r_lrck;
    logic [c_half_bits:0] w_last;
    logic [c_half_bits:0] w_rise;

    assign w_last       = {i_half, 1'b0} - 1'b1;
    assign w_rise       = {1'b0, i_half} - 1'b1;
    assign o_fall       = i_enable && (r_div_cnt == w_last);
    assign o_frame_wrap = o_fall && (r_bit_cnt == 6'(FRAME_BITS - 1));
    assign o_next_bit   = r_bit_cnt + 6'd1;
    assign o_bck        = r_bck;
    assign o_lrck       = r_lrck;

    // Disabled means parked at the start of a frame with both clocks low.
    always_ff @(posedge clk) begin
        if (rst || !i_enable) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_bck     <= 1'b0;
            r_lrck    <= 1'b0;
        end else if (o_fall) begin
            r_div_cnt <= '0;
            r_bit_cnt <= o_next_bit;
            r_bck     <= 1'b0;
            r_lrck    <= o_next_bit[5];
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            if (r_div_cnt == w_rise) begin
                r_bck <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_master_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : i2s_master_scheduler
// Brief    : I2S master with per-frame FIFO fetch, start/stop sequencing and
//            underrun tracking. I2S_UNDERRUN_REPEAT_EN repeats the previous
//            frame on underrun instead of playing silence.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_master_scheduler
    import i2s_pkg::*;
#(
    parameter int SAMPLE_BITS       = 24,
    parameter int FETCH_BIT         = 56,
    parameter int UNDERRUN_CNT_BITS = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic [1:0]                   ratio_sel,
    input  logic                         width_sel,
    output logic                         samples_ready,
    input  logic                         samples_enable,
    input  logic [2*SAMPLE_BITS-1:0]     samples_data,
    output logic                         bck,
    output logic                         lrck,
    output logic                         sdata,
    output logic                         running,
    output logic                         underrun,
    output logic [UNDERRUN_CNT_BITS-1:0] underrun_count
);

    localparam int c_idx_bits = $clog2(SAMPLE_BITS);

    fsm_state_t                   r_state, w_state_next;
    logic                         r_ready, r_shadow_valid, r_sdata, r_underrun, r_w16;
    logic [c_half_bits-1:0]       r_half;
    logic [2*SAMPLE_BITS-1:0]     r_shadow, r_hold;
    logic [UNDERRUN_CNT_BITS-1:0] r_ucnt;
    logic                         w_xfer, w_active, w_fall, w_wrap, w_stop_now, w_play_wrap, w_bit;
    logic [5:0]                   w_next_bit;
    logic [4:0]                   w_pos;
    logic [SAMPLE_BITS-1:0]       w_chan;
    logic [c_idx_bits-1:0]        w_idx;

    i2s_clock_divider u_div (
        .clk          (clk),
        .rst          (reset),
        .i_enable     (w_active),
        .i_half       (r_half),
        .o_bck        (bck),
        .o_lrck       (lrck),
        .o_fall       (w_fall),
        .o_frame_wrap (w_wrap),
        .o_next_bit   (w_next_bit)
    );

    assign w_xfer      = r_ready && samples_enable;
    assign w_active    = (r_state == RUN) || (r_state == STOPPING);
    assign w_stop_now  = (r_state == STOPPING) && w_wrap && !run;
    assign w_play_wrap = w_wrap && !w_stop_now;

    assign samples_ready  = r_ready;
    assign sdata          = r_sdata;
    assign running        = w_active;
    assign underrun       = r_underrun;
    assign underrun_count = r_ucnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (run) w_state_next = PREFETCH;
            PREFETCH: if (w_xfer) w_state_next = RUN;
                      else if (!run) w_state_next = IDLE;
            RUN:      if (!run) w_state_next = STOPPING;
            STOPPING: if (run) w_state_next = RUN;
                      else if (w_wrap) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_half <= ratio_to_half(2'd1);
            r_w16  <= 1'b0;
        end else if ((r_state == IDLE) && run) begin
            r_half <= ratio_to_half(ratio_sel);
            r_w16  <= width_sel;
        end
    end

    // No new fetch is offered once a stop has been requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE:     r_ready <= run;
                PREFETCH: r_ready <= run && !w_xfer;
                default: begin
                    if (w_xfer || (r_state == STOPPING)) begin
                        r_ready <= 1'b0;
                    end else if (w_fall && (w_next_bit == 6'(FETCH_BIT)) && !r_shadow_valid) begin
                        r_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow_valid <= 1'b0;
            r_shadow       <= '0;
        end else if (!w_active || w_stop_now) begin
            r_shadow_valid <= 1'b0;
        end else if (w_xfer) begin
            r_shadow_valid <= 1'b1;
            r_shadow       <= samples_data;
        end else if (w_wrap) begin
            r_shadow_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold <= '0;
        end else if ((r_state == PREFETCH) && w_xfer) begin
            r_hold <= samples_data;
        end else if (w_play_wrap) begin
            if (r_shadow_valid) begin
                r_hold <= r_shadow;
            end else begin
`ifdef I2S_UNDERRUN_REPEAT_EN
                r_hold <= r_hold;
`else
                r_hold <= '0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun <= 1'b0;
            r_ucnt     <= '0;
        end else if ((r_state == IDLE) && run) begin
            r_underrun <= 1'b0;
        end else if (w_play_wrap && !r_shadow_valid) begin
            r_underrun <= 1'b1;
            if (r_ucnt != '1) begin
                r_ucnt <= r_ucnt + 1'b1;
            end
        end
    end

    // 16-bit words are the top of each channel half, so both widths share one index.
    assign w_pos  = w_next_bit[4:0];
    assign w_chan = w_next_bit[5] ? r_hold[SAMPLE_BITS-1:0] : r_hold[2*SAMPLE_BITS-1:SAMPLE_BITS];
    assign w_idx  = c_idx_bits'(SAMPLE_BITS - int'(w_pos));

    always_comb begin
        w_bit = 1'b0;
        if ((w_pos != 5'd0) && (int'(w_pos) <= (r_w16 ? 16 : SAMPLE_BITS))) begin
            w_bit = w_chan[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !w_active) begin
            r_sdata <= 1'b0;
        end else if (w_fall) begin
            r_sdata <= w_bit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_master_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_master_scheduler
// Brief    : Directed/randomised bench for i2s_master_scheduler against a
//            frame-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_master_scheduler;

    localparam int SB  = 24;
    localparam int UCB = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           run = 1'b0;
    logic [1:0]     ratio_sel = 2'd1;
    logic           width_sel = 1'b0;
    logic           samples_enable = 1'b0;
    logic [2*SB-1:0] samples_data = '0;
    logic           samples_ready, bck, lrck, sdata, running, underrun;
    logic [UCB-1:0] underrun_count;

    i2s_master_scheduler #(
        .SAMPLE_BITS       (SB),
        .FETCH_BIT         (56),
        .UNDERRUN_CNT_BITS (UCB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .ratio_sel      (ratio_sel),
        .width_sel      (width_sel),
        .samples_ready  (samples_ready),
        .samples_enable (samples_enable),
        .samples_data   (samples_data),
        .bck            (bck),
        .lrck           (lrck),
        .sdata          (sdata),
        .running        (running),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: m_st 0=idle, 1=prefetch, 2=streaming; m_j = clk edges since start
    int          m_st = 0;
    bit          m_stopping = 1'b0;
    int          m_half = 2;
    bit          m_w16 = 1'b0;
    int          m_j = 0;
    bit          m_ready = 1'b0;
    bit          m_sv = 1'b0;
    bit          m_under = 1'b0;
    int          m_ucnt = 0;
    logic [47:0] m_shadow = '0;
    logic [47:0] m_hold = '0;

    int          prod_mode = 0;
    logic [47:0] cur_data = '0;
    logic [47:0] last_data = '0;
    logic [47:0] data_q[$];

    function automatic logic [47:0] rnd48();
        return 48'({$urandom(), $urandom()});
    endfunction

    function automatic int bit_now();
        return (m_j / (2 * m_half)) % 64;
    endfunction

    function automatic bit next_is_wrap();
        return (m_st == 2) && (((m_j + 1) % (2 * m_half)) == 0) &&
               ((((m_j + 1) / (2 * m_half)) % 64) == 0);
    endfunction

    task automatic model_edge();
        bit xfer, fall, wrap;
        int b;
        xfer = m_ready && samples_enable;
        if (reset) begin
            m_st = 0; m_stopping = 0; m_ready = 0; m_sv = 0;
            m_under = 0; m_ucnt = 0; m_hold = '0; m_j = 0;
            return;
        end
        case (m_st)
            0: if (run) begin
                m_half  = (ratio_sel == 2'd0) ? 1 : (ratio_sel == 2'd2) ? 4 : 2;
                m_w16   = width_sel;
                m_under = 0;
                m_ready = 1;
                m_st    = 1;
            end
            1: if (xfer) begin
                m_hold = samples_data; m_ready = 0; m_j = 0; m_st = 2; m_stopping = 0;
            end else if (!run) begin
                m_st = 0; m_ready = 0;
            end
            default: begin
                m_j++;
                fall = (m_j % (2 * m_half)) == 0;
                b    = bit_now();
                wrap = fall && (b == 0);
                if (m_stopping && wrap && !run) begin
                    m_st = 0; m_ready = 0; m_sv = 0; m_stopping = 0;
                end else begin
                    if (wrap) begin
                        if (m_sv) begin
                            m_hold = m_shadow; m_sv = 0;
                        end else begin
                            m_under = 1;
                            if (m_ucnt < (2 ** UCB) - 1) m_ucnt++;
`ifndef I2S_UNDERRUN_REPEAT_EN
                            m_hold = '0;
`endif
                        end
                    end
                    if (xfer) begin
                        m_shadow = samples_data; m_sv = 1; m_ready = 0;
                    end else if (m_stopping) begin
                        m_ready = 0;
                    end else if (fall && (b == 56) && !m_sv) begin
                        m_ready = 1;
                    end
                    m_stopping = !run;
                end
            end
        endcase
    endtask

    task automatic check_cycle();
        logic [5:0]  exp_v, obs_v;
        logic [23:0] ch;
        bit eb, el, es;
        int b, p, w;
        eb = 0; el = 0; es = 0;
        if (m_st == 2) begin
            b  = bit_now();
            eb = (m_j % (2 * m_half)) >= m_half;
            el = (b >= 32);
            p  = b % 32;
            w  = m_w16 ? 16 : 24;
            ch = el ? m_hold[23:0] : m_hold[47:24];
            if (p >= 1 && p <= w) es = ch[5'(24 - p)];
        end
        exp_v = {(m_st == 2), eb, el, es, m_ready, m_under};
        obs_v = {running, bck, lrck, sdata, samples_ready, underrun};
        tests++;
        assert (obs_v === exp_v && underrun_count === UCB'(m_ucnt)) else begin
            fails++;
            $error("FAIL cycle t=%0t {running,bck,lrck,sdata,ready,underrun} got %b cnt %0d want %b cnt %0d",
                   $time, obs_v, underrun_count, exp_v, m_ucnt);
        end
    endtask

    task automatic drive();
        samples_data = cur_data;
        case (prod_mode)
            0:       samples_enable = 1'b1;
            1:       samples_enable = (m_st == 1);
            2:       samples_enable = (m_st == 1) || next_is_wrap();
            default: samples_enable = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic step();
        bit xfer;
        @(posedge clk);
        xfer = m_ready && samples_enable && !reset;
        model_edge();
        if (xfer) begin
            last_data = samples_data;
            if (data_q.size() > 0) cur_data = data_q.pop_front();
            else cur_data = rnd48();
        end
        #1;
        check_cycle();
        drive();
    endtask

    task automatic expect_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wait_bit(input int b);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(m_st == 2 && (m_j % (2 * m_half)) == 0 && bit_now() == b) && n < 1200);
        if (n >= 1200) begin
            tests++; fails++;
            $error("FAIL wait_bit %0d: timed out after %0d cycles", b, n);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_st != 0 && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) begin
            tests++; fails++;
            $error("FAIL wait_idle: timed out after %0d cycles", n);
        end
    endtask

    task automatic collect(input int first, input int n, output logic [47:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            wait_bit(first + i);
            v = {v[46:0], sdata};
        end
    endtask

    logic [47:0] v;
    logic [47:0] saved;

    initial begin
        cur_data = 48'hA5A5A5_5A5A5A;
        data_q.push_back(48'h123456_654321);
        reset = 1'b1;
        repeat (3) step();
        expect_eq("reset_outputs", {42'd0, bck, lrck, sdata, running, samples_ready, underrun}, 48'd0);
        expect_eq("reset_count", 48'(underrun_count), 48'd0);
        reset = 1'b0;
        step();

        // 256Fs, 24-bit
        ratio_sel = 2'd1; width_sel = 1'b0; run = 1'b1;
        collect(1, 24, v);  expect_eq("left_24b_A5A5A5", v, 48'hA5A5A5);
        collect(25, 7, v);  expect_eq("left_pad_zero", v, 48'h0);
        collect(33, 24, v); expect_eq("right_24b_5A5A5A", v, 48'h5A5A5A);
        collect(1, 24, v);  expect_eq("left_24b_123456", v, 48'h123456);
        collect(33, 24, v); expect_eq("right_24b_654321", v, 48'h654321);
        prod_mode = 3;
        repeat (2 * 64 * 4) step();

        // Stop at bit 10, frame completes, clean return to idle
        prod_mode = 0;
        wait_bit(10);
        run = 1'b0;
        wait_idle();
        repeat (10) step();
        expect_eq("stopped_outputs", {43'd0, bck, lrck, sdata, running, samples_ready}, 48'd0);

        // 128Fs, 16-bit; ratio change while running must not take effect
        cur_data = 48'hBEEF00_CAFE00;
        ratio_sel = 2'd0; width_sel = 1'b1; run = 1'b1;
        step();
        expect_eq("underrun_cleared_on_start", 48'(underrun), 48'd0);
        collect(1, 16, v);  expect_eq("left_16b_BEEF", v, 48'hBEEF);
        collect(17, 15, v); expect_eq("left_16b_pad", v, 48'h0);
        collect(33, 16, v); expect_eq("right_16b_CAFE", v, 48'hCAFE);
        ratio_sel = 2'd2;
        repeat (2 * 64 * 2) step();

        // One withheld fetch -> one underrun frame
        wait_bit(40);
        prod_mode = 1;
        wait_bit(0);
        prod_mode = 0;
        expect_eq("underrun_flag", 48'(underrun), 48'd1);
        saved = last_data;
        collect(1, 16, v);
`ifdef I2S_UNDERRUN_REPEAT_EN
        expect_eq("underrun_frame_left", v, 48'(saved[47:32]));
`else
        expect_eq("underrun_frame_left", v, 48'h0);
`endif
        repeat (2 * 64 * 2) step();

        // Transfer landing exactly on the frame wrap
        wait_bit(40);
        prod_mode = 2;
        wait_bit(0);
        prod_mode = 0;
        saved = last_data;
        wait_bit(63);
        collect(1, 16, v);
        expect_eq("wrap_xfer_plays_next_frame", v, 48'(saved[47:32]));

        // Counter saturation
        prod_mode = 1;
        repeat (18 * 64 * 2) step();
        expect_eq("underrun_count_saturated", 48'(underrun_count), 48'hF);
        prod_mode = 0;
        run = 1'b0;
        wait_idle();

        // 512Fs, 24-bit, random producer timing
        ratio_sel = 2'd2; width_sel = 1'b0; run = 1'b1; prod_mode = 3;
        step();
        expect_eq("underrun_cleared_512", 48'(underrun), 48'd0);
        repeat (3 * 64 * 8) step();

        // Reset mid-frame
        wait_bit(40);
        reset = 1'b1;
        step();
        expect_eq("mid_frame_reset", {38'd0, bck, lrck, sdata, running, samples_ready, underrun, underrun_count},
                  48'd0);
        reset = 1'b0;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
